// File: rtl/hex_display_scan.sv
// hex_display_scan: drives a 4-digit common-anode seven-segment display from a
// per-frame snapshot of a 16-bit word, with leading-zero blanking and decimal points.
//
// state | meaning
// DIG0  | rightmost digit, display[3:0]
// DIG1  | display[7:4]
// DIG2  | display[11:8]
// DIG3  | leftmost digit, display[15:12]; its last tick wraps the frame
module hex_display_scan #(
    parameter int SCAN_DIV = 50000,
    parameter int CNT_W    = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] display,
    input  logic        blank_lz,
    input  logic [3:0]  dp_en,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_done
);

    typedef enum logic [1:0] {DIG0 = 2'd0, DIG1 = 2'd1, DIG2 = 2'd2, DIG3 = 2'd3} digit_e;

    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(SCAN_DIV - 1);

    logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
    digit_e           digit_q, digit_d;
    logic [15:0]      disp_sh_q, disp_sh_d;
    logic [3:0]       dp_en_sh_q, dp_en_sh_d;
    logic             blank_lz_sh_q, blank_lz_sh_d;
    logic [3:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic             dp_q, dp_d;

    logic             tick;
    logic             wrap;
    logic [3:0]       nibble;
    logic [6:0]       seg_on;
    logic [3:0]       an_lit;
    logic             dp_bit;
    logic             blank;

    assign tick = (div_cnt_q == DIV_LAST);
    assign wrap = tick && (digit_q == DIG3);

    always_ff @(posedge clk) begin
        if (!rst) begin
            div_cnt_q     <= '0;
            digit_q       <= DIG0;
            disp_sh_q     <= '0;
            dp_en_sh_q    <= '0;
            blank_lz_sh_q <= 1'b0;
            an_q          <= 4'hF;
            seg_q         <= 7'h7F;
            dp_q          <= 1'b1;
        end else begin
            div_cnt_q     <= div_cnt_d;
            digit_q       <= digit_d;
            disp_sh_q     <= disp_sh_d;
            dp_en_sh_q    <= dp_en_sh_d;
            blank_lz_sh_q <= blank_lz_sh_d;
            an_q          <= an_d;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
        end
    end

    // Snapshot is taken only at frame wrap so a frame never mixes two input words.
    always_comb begin
        div_cnt_d     = tick ? '0 : div_cnt_q + CNT_W'(1);
        digit_d       = digit_q;
        disp_sh_d     = disp_sh_q;
        dp_en_sh_d    = dp_en_sh_q;
        blank_lz_sh_d = blank_lz_sh_q;
        if (tick) begin
            case (digit_q)
                DIG0: digit_d = DIG1;
                DIG1: digit_d = DIG2;
                DIG2: digit_d = DIG3;
                DIG3: digit_d = DIG0;
            endcase
        end
        if (wrap) begin
            disp_sh_d     = display;
            dp_en_sh_d    = dp_en;
            blank_lz_sh_d = blank_lz;
        end
    end

    always_comb begin
        nibble = 4'h0;
        an_lit = 4'hF;
        dp_bit = 1'b0;
        blank  = 1'b0;
        case (digit_q)
            DIG0: begin
                nibble = disp_sh_q[3:0];
                an_lit = 4'b1110;
                dp_bit = dp_en_sh_q[0];
            end
            DIG1: begin
                nibble = disp_sh_q[7:4];
                an_lit = 4'b1101;
                dp_bit = dp_en_sh_q[1];
                blank  = blank_lz_sh_q && (disp_sh_q[15:4] == 12'h000);
            end
            DIG2: begin
                nibble = disp_sh_q[11:8];
                an_lit = 4'b1011;
                dp_bit = dp_en_sh_q[2];
                blank  = blank_lz_sh_q && (disp_sh_q[15:8] == 8'h00);
            end
            DIG3: begin
                nibble = disp_sh_q[15:12];
                an_lit = 4'b0111;
                dp_bit = dp_en_sh_q[3];
                blank  = blank_lz_sh_q && (disp_sh_q[15:12] == 4'h0);
            end
        endcase

        case (nibble)
            4'h0: seg_on = 7'h3F;
            4'h1: seg_on = 7'h06;
            4'h2: seg_on = 7'h5B;
            4'h3: seg_on = 7'h4F;
            4'h4: seg_on = 7'h66;
            4'h5: seg_on = 7'h6D;
            4'h6: seg_on = 7'h7D;
            4'h7: seg_on = 7'h07;
            4'h8: seg_on = 7'h7F;
            4'h9: seg_on = 7'h6F;
            4'hA: seg_on = 7'h77;
            4'hB: seg_on = 7'h7C;
            4'hC: seg_on = 7'h39;
            4'hD: seg_on = 7'h5E;
            4'hE: seg_on = 7'h79;
            4'hF: seg_on = 7'h71;
        endcase

        an_d  = blank ? 4'hF : an_lit;
        seg_d = blank ? 7'h7F : ~seg_on;
        dp_d  = blank | ~dp_bit;
        // Gated by rst so a wrap coinciding with reset is never reported.
        frame_done = wrap & rst;
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule

// File: tb/tb_hex_display_scan.sv
// Testbench for hex_display_scan: one instance at SCAN_DIV=4 for frame-level
// behaviour, one at SCAN_DIV=1 for reset abort and every-cycle scanning.
module tb_hex_display_scan;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst4, rst1;
    logic [15:0] display;
    logic        blank_lz;
    logic [3:0]  dp_en;
    logic [3:0]  an4, an1;
    logic [6:0]  seg4, seg1;
    logic        dp4, dp1, fd4, fd1;

    hex_display_scan #(.SCAN_DIV(4), .CNT_W(2)) dut4 (
        .clk(clk), .rst(rst4), .display(display), .blank_lz(blank_lz), .dp_en(dp_en),
        .an(an4), .seg(seg4), .dp(dp4), .frame_done(fd4)
    );

    hex_display_scan #(.SCAN_DIV(1), .CNT_W(1)) dut1 (
        .clk(clk), .rst(rst1), .display(display), .blank_lz(blank_lz), .dp_en(dp_en),
        .an(an1), .seg(seg1), .dp(dp1), .frame_done(fd1)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [11:0] sb_q[$];
    logic [11:0] obs[4];
    logic [11:0] exp_v;
    int          fd_mid;
    logic        fd_end;
    bit          sync_ok;

    function automatic logic [6:0] hex_on(input logic [3:0] n);
        logic [6:0] t [16];
        t = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        return t[n];
    endfunction

    // Expected {an, seg, dp} for digit d of a frame showing snapshot v.
    function automatic logic [11:0] model(input logic [15:0] v, input logic blz,
                                         input logic [3:0] dpe, input int d);
        logic [15:0] hi;
        logic [3:0]  one_hot;
        hi = v >> (4 * d);
        if (blz && d != 0 && hi == 16'h0000)
            return {4'hF, 7'h7F, 1'b1};
        one_hot = 4'b0001 << d;
        return {~one_hot, ~hex_on(v[4*d +: 4]), ~dpe[d]};
    endfunction

    task automatic push_frame(input logic [15:0] v, input logic blz, input logic [3:0] dpe);
        for (int d = 0; d < 4; d++) sb_q.push_back(model(v, blz, dpe, d));
    endtask

    task automatic wait_frame(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (fd4 === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    // Called on the negedge of a wrap cycle; samples each digit mid-slot and
    // ends on the negedge of the next wrap cycle.
    task automatic grab_frame(input int chg_edge, input logic [15:0] chg_val);
        fd_mid = 0;
        for (int e = 1; e <= 16; e++) begin
            @(negedge clk);
            if (e == 3 || e == 7 || e == 11 || e == 15) obs[(e - 3) / 4] = {an4, seg4, dp4};
            if (e < 16 && fd4 === 1'b1) fd_mid++;
            if (e == chg_edge) display = chg_val;
        end
        fd_end = fd4;
    endtask

    task automatic sync_to_frame(input string name);
        wait_frame(40, sync_ok);
        n_checks++;
        if (!sync_ok) begin
            n_fail++;
            $display("FAIL %s sync: frame_done not seen within 40 cycles", name);
        end
    endtask

    task automatic test_reset;
        rst4 = 1'b0; rst1 = 1'b0;
        display = 16'h0000; blank_lz = 1'b0; dp_en = 4'h0;
        repeat (3) @(negedge clk);
        sb_q.push_back({4'hF, 7'h7F, 1'b1});
        exp_v = sb_q.pop_front();
        n_checks++;
        if ({an4, seg4, dp4} !== exp_v || fd4 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got an=%b seg=%h dp=%b fd=%b, expected an=%b seg=%h dp=%b fd=0",
                     an4, seg4, dp4, fd4, exp_v[11:8], exp_v[7:1], exp_v[0]);
        end
        rst4 = 1'b1;
        for (int k = 0; k < 8; k++) begin
            sb_q.push_back({~(4'b0001 << (k / 4)), 7'h40, 1'b1});
            @(negedge clk);
            exp_v = sb_q.pop_front();
            n_checks++;
            if ({an4, seg4, dp4} !== exp_v) begin
                n_fail++;
                $display("FAIL post_reset cycle%0d: got an=%b seg=%h dp=%b, expected an=%b seg=%h dp=%b",
                         k, an4, seg4, dp4, exp_v[11:8], exp_v[7:1], exp_v[0]);
            end
        end
    endtask

    task automatic check_frame(input string name);
        for (int d = 0; d < 4; d++) begin
            exp_v = sb_q.pop_front();
            n_checks++;
            if (obs[d] !== exp_v) begin
                n_fail++;
                $display("FAIL %s digit%0d: got an=%b seg=%h dp=%b, expected an=%b seg=%h dp=%b",
                         name, d, obs[d][11:8], obs[d][7:1], obs[d][0],
                         exp_v[11:8], exp_v[7:1], exp_v[0]);
            end
        end
        n_checks++;
        if (fd_mid !== 0 || fd_end !== 1'b1) begin
            n_fail++;
            $display("FAIL %s frame_done: got %0d mid-frame pulses and end=%b, expected 0 and 1",
                     name, fd_mid, fd_end);
        end
    endtask

    task automatic test_scan_order;
        display = 16'h1A2F;
        sync_to_frame("scan_order");
        push_frame(16'h1A2F, 1'b0, 4'h0);
        grab_frame(0, 16'h0000);
        check_frame("scan_order");
    endtask

    task automatic test_snapshot;
        sync_to_frame("snapshot");
        display = 16'h1234;
        push_frame(16'h1234, 1'b0, 4'h0);
        grab_frame(7, 16'hBEEF);
        check_frame("snapshot_hold");
        push_frame(16'hBEEF, 1'b0, 4'h0);
        grab_frame(0, 16'h0000);
        check_frame("snapshot_new");
    endtask

    task automatic test_blank;
        logic [15:0] vals[3];
        vals = '{16'h0005, 16'h0000, 16'h0100};
        for (int i = 0; i < 3; i++) begin
            sync_to_frame("blank");
            blank_lz = 1'b1;
            display  = vals[i];
            push_frame(vals[i], 1'b1, 4'h0);
            grab_frame(0, vals[i]);
            check_frame($sformatf("blank_%h", vals[i]));
        end
    endtask

    task automatic test_dp;
        sync_to_frame("dp");
        blank_lz = 1'b0; dp_en = 4'b0101; display = 16'h8C3D;
        push_frame(16'h8C3D, 1'b0, 4'b0101);
        grab_frame(0, 16'h8C3D);
        check_frame("dp_0101");
        sync_to_frame("dp_blank");
        blank_lz = 1'b1; dp_en = 4'b1111; display = 16'h0050;
        push_frame(16'h0050, 1'b1, 4'b1111);
        grab_frame(0, 16'h0050);
        check_frame("dp_blank");
    endtask

    task automatic test_reset_abort;
        display = 16'h0000; blank_lz = 1'b0; dp_en = 4'h0;
        rst1 = 1'b1;
        for (int k = 0; k < 2; k++) begin
            sb_q.push_back({~(4'b0001 << k), 7'h40, 1'b1});
            @(negedge clk);
            exp_v = sb_q.pop_front();
            n_checks++;
            if ({an1, seg1, dp1} !== exp_v || fd1 !== 1'b0) begin
                n_fail++;
                $display("FAIL abort_pre cycle%0d: got an=%b seg=%h dp=%b fd=%b, expected an=%b seg=%h dp=%b fd=0",
                         k, an1, seg1, dp1, fd1, exp_v[11:8], exp_v[7:1], exp_v[0]);
            end
        end
        rst1 = 1'b0;
        @(negedge clk);
        rst1 = 1'b1;
        #1;
        sb_q.push_back({4'hF, 7'h7F, 1'b1});
        exp_v = sb_q.pop_front();
        n_checks++;
        if ({an1, seg1, dp1} !== exp_v || fd1 !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_reset: got an=%b seg=%h dp=%b fd=%b, expected an=%b seg=%h dp=%b fd=0",
                     an1, seg1, dp1, fd1, exp_v[11:8], exp_v[7:1], exp_v[0]);
        end
        for (int k = 0; k < 8; k++) begin
            sb_q.push_back({~(4'b0001 << (k % 4)), 7'h40, 1'b1});
            @(negedge clk);
            exp_v = sb_q.pop_front();
            n_checks++;
            if ({an1, seg1, dp1} !== exp_v || fd1 !== ((k % 4) == 2)) begin
                n_fail++;
                $display("FAIL abort_post cycle%0d: got an=%b seg=%h dp=%b fd=%b, expected an=%b seg=%h dp=%b fd=%0d",
                         k, an1, seg1, dp1, fd1, exp_v[11:8], exp_v[7:1], exp_v[0], (k % 4) == 2);
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan_order();
        test_snapshot();
        test_blank();
        test_dp();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
